sort_result_reader: RTL and testbench

//   Read-side consumer for the bubblesort engine's parallel result interface.

---
 rtl/sort_result_reader_if.sv | 14 +
 rtl/sort_result_reader.sv | 82 ++++++++
 tb/tb_sort_result_reader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_result_reader_if.sv
// Result stream port of sort_result_reader: one sorted element per valid/ready beat.
interface sort_result_reader_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/sort_result_reader.sv
// Captures the bubblesort engine's parallel results on one rd_en strobe, streams them
// out one beat at a time, and counts adjacent order violations along the way.
module sort_result_reader #(
  parameter int DATA_W = 16,
  parameter int N      = 10,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sort_done,
  output logic                  rd_en,
  input  logic [N*DATA_W-1:0]   dat_in,
  sort_result_reader_if.master  out_if,
  output logic                  check_done,
  output logic                  sorted_ok,
  output logic [IDX_W-1:0]      err_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] data_buf [N];
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              at_last;
  logic              order_err;

  assign accept    = (state == STREAM) && out_if.out_ready;
  assign at_last   = (idx == LAST_IDX);
  // Buffer is frozen during STREAM, so the previous element is read straight from it.
  assign order_err = (idx != '0) && (data_buf[idx] < data_buf[idx - 1'b1]);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sort_done)         state_nx = REQ;
      REQ:                            state_nx = STREAM;
      STREAM:  if (accept && at_last) state_nx = DONE;
      DONE:    if (!sort_done)        state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) data_buf[i] <= '0;
      idx     <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        REQ: begin
          for (int unsigned i = 0; i < N; i++) data_buf[i] <= dat_in[i*DATA_W +: DATA_W];
          idx     <= '0;
          err_cnt <= '0;
        end
        STREAM: begin
          if (accept) begin
            if (order_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
            if (!at_last) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en            = (state == REQ);
  assign out_if.out_valid = (state == STREAM);
  assign out_if.out_data  = data_buf[idx];
  assign out_if.out_idx   = idx;
  assign out_if.out_last  = (state == STREAM) && at_last;
  assign check_done       = (state == DONE);
  assign sorted_ok        = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_sort_result_reader.sv
// Directed bench for sort_result_reader: capture, streaming, stalls, reset and re-arm.
module tb_sort_result_reader;
  localparam int DATA_W = 16;
  localparam int N      = 10;
  localparam int IDX_W  = 4;
  localparam int DW     = N * DATA_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sort_done = 1'b0;
  logic             rd_en;
  logic [DW-1:0]    dat_in = '0;
  logic             check_done;
  logic             sorted_ok;
  logic [IDX_W-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  sort_result_reader_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) sif ();

  sort_result_reader #(.DATA_W(DATA_W), .N(N), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sort_done  (sort_done),
    .rd_en      (rd_en),
    .dat_in     (dat_in),
    .out_if     (sif),
    .check_done (check_done),
    .sorted_ok  (sorted_ok),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] v_sorted [N] = '{16'h1, 16'h2, 16'h3, 16'h10, 16'h10,
                                      16'h50, 16'h50, 16'h100, 16'h300, 16'h500};
  logic [DATA_W-1:0] v_err    [N] = '{16'h1, 16'h2, 16'h3, 16'h10, 16'h03,
                                      16'h50, 16'h50, 16'h100, 16'h300, 16'h500};
  logic [DATA_W-1:0] v_desc   [N] = '{16'h500, 16'h300, 16'h100, 16'h50, 16'h40,
                                      16'h10, 16'h4, 16'h3, 16'h2, 16'h1};

  function automatic logic [DW-1:0] pack(input logic [DATA_W-1:0] e [N]);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = e[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one capture and collects the stream until check_done (bounded).
  task automatic run_capture(input logic [DW-1:0] d, input bit stall,
                             output logic [DW-1:0] got, output int beats,
                             output int rd_pulses, output int bad_beats,
                             output int t_rd, output int t_valid, output int t_done,
                             output bit timeout);
    logic             pv, pr, pl;
    logic [DATA_W-1:0] pd;
    logic [IDX_W-1:0]  pi;
    got = '0; beats = 0; rd_pulses = 0; bad_beats = 0;
    t_rd = -1; t_valid = -1; t_done = -1; timeout = 1'b1;
    dat_in = d;
    sort_done = 1'b1;
    sif.out_ready = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      pv = sif.out_valid; pr = sif.out_ready; pd = sif.out_data;
      pi = sif.out_idx;   pl = sif.out_last;
      if (pv && pr) begin
        if (beats >= N || int'(pi) != beats || pl != (beats == N-1) ||
            pd !== d[beats*DATA_W +: DATA_W]) bad_beats++;
        if (beats < N) got[beats*DATA_W +: DATA_W] = pd;
        beats++;
      end
      tick();
      if (rd_en) begin
        rd_pulses++;
        if (t_rd < 0) t_rd = c;
      end
      if (sif.out_valid && t_valid < 0) t_valid = c;
      if (pv && !pr) begin
        if (!sif.out_valid || sif.out_data !== pd || sif.out_idx !== pi ||
            sif.out_last !== pl) bad_beats++;
      end
      if (check_done) begin
        t_done = c;
        timeout = 1'b0;
        break;
      end
      if (stall) sif.out_ready = (c % 3 == 0);
    end
    sif.out_ready = 1'b1;
  endtask

  task automatic rearm();
    sort_done = 1'b0;
    tick();
    checks++;
    if (check_done !== 1'b0) begin
      errors++;
      $display("FAIL rearm_exit_done: check_done=%0b expected 0", check_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; sort_done = 1'b0; sif.out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({rd_en, sif.out_valid, sif.out_last, check_done, sorted_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: {rd_en,valid,last,done,ok}=%b expected 00000",
               {rd_en, sif.out_valid, sif.out_last, check_done, sorted_ok});
    end
    checks++;
    if (sif.out_data !== '0 || sif.out_idx !== '0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_values: data=%0h idx=%0d err=%0d expected 0 0 0",
               sif.out_data, sif.out_idx, err_cnt);
    end
    reset = 1'b1;
    sif.out_ready = 1'b1;
    tick();
    checks++;
    if (sif.out_valid !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_done: valid=%0b rd_en=%0b expected 0 0", sif.out_valid, rd_en);
    end
  endtask

  task automatic check_common(input string name, input logic [DW-1:0] d,
                              input logic [DW-1:0] got, input int beats, input int rd_pulses,
                              input int bad, input bit timeout,
                              input int exp_err, input logic exp_ok);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: check_done never seen", name);
    end
    checks++;
    if (beats != N || rd_pulses != 1) begin
      errors++;
      $display("FAIL %s_counts: beats=%0d rd_pulses=%0d expected %0d 1", name, beats, rd_pulses, N);
    end
    checks++;
    if (bad != 0 || got !== d) begin
      errors++;
      $display("FAIL %s_beats: bad=%0d got=%h expected bad=0 data=%h", name, bad, got, d);
    end
    checks++;
    if (int'(err_cnt) != exp_err || sorted_ok !== exp_ok) begin
      errors++;
      $display("FAIL %s_result: err_cnt=%0d sorted_ok=%0b expected %0d %0b",
               name, err_cnt, sorted_ok, exp_err, exp_ok);
    end
  endtask

  task automatic test_sorted();
    logic [DW-1:0] got;
    int beats, rdp, bad, t_rd, t_valid, t_done;
    bit to;
    run_capture(pack(v_sorted), 1'b0, got, beats, rdp, bad, t_rd, t_valid, t_done, to);
    check_common("sorted", pack(v_sorted), got, beats, rdp, bad, to, 0, 1'b1);
    checks++;
    if (t_rd != 1 || t_valid != 2 || t_done != 2 + N) begin
      errors++;
      $display("FAIL sorted_latency: rd=%0d valid=%0d done=%0d expected 1 2 %0d",
               t_rd, t_valid, t_done, 2 + N);
    end
    checks++;
    if (sif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_valid_low: out_valid=%0b expected 0", sif.out_valid);
    end
    rearm();
  endtask

  task automatic test_one_error();
    logic [DW-1:0] got;
    int beats, rdp, bad, t_rd, t_valid, t_done;
    bit to;
    run_capture(pack(v_err), 1'b0, got, beats, rdp, bad, t_rd, t_valid, t_done, to);
    check_common("one_error", pack(v_err), got, beats, rdp, bad, to, 1, 1'b0);
    rearm();
  endtask

  task automatic test_stall();
    logic [DW-1:0] got;
    int beats, rdp, bad, t_rd, t_valid, t_done;
    bit to;
    run_capture(pack(v_sorted), 1'b1, got, beats, rdp, bad, t_rd, t_valid, t_done, to);
    check_common("stall", pack(v_sorted), got, beats, rdp, bad, to, 0, 1'b1);
    checks++;
    if (t_done <= 2 + N) begin
      errors++;
      $display("FAIL stall_slowed: done_cycle=%0d expected > %0d", t_done, 2 + N);
    end
    rearm();
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] got;
    int beats, rdp, bad, t_rd, t_valid, t_done;
    bit to, found;
    found = 1'b0;
    dat_in = pack(v_err);
    sort_done = 1'b1;
    sif.out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (sif.out_valid && sif.out_idx == 4'd4) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_reach: beat 4 never presented");
    end
    tick();
    checks++;
    if (err_cnt !== 4'd1 || sif.out_idx !== 4'd5) begin
      errors++;
      $display("FAIL midreset_pre: err_cnt=%0d idx=%0d expected 1 5", err_cnt, sif.out_idx);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (sif.out_valid !== 1'b0 || err_cnt !== '0 || sif.out_idx !== '0 ||
        check_done !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%0b err=%0d idx=%0d done=%0b rd=%0b expected 0 0 0 0 0",
               sif.out_valid, err_cnt, sif.out_idx, check_done, rd_en);
    end
    reset = 1'b1;
    run_capture(pack(v_sorted), 1'b0, got, beats, rdp, bad, t_rd, t_valid, t_done, to);
    check_common("after_reset", pack(v_sorted), got, beats, rdp, bad, to, 0, 1'b1);
  endtask

  task automatic test_stuck_done();
    int rdp;
    rdp = 0;
    sort_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rd_en) rdp++;
    end
    checks++;
    if (rdp != 0 || check_done !== 1'b1) begin
      errors++;
      $display("FAIL stuck_no_recapture: rd_pulses=%0d done=%0b expected 0 1", rdp, check_done);
    end
    sort_done = 1'b0;
    tick();
    sort_done = 1'b1;
    rdp = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rd_en) rdp++;
    end
    checks++;
    if (rdp != 1 || check_done !== 1'b1) begin
      errors++;
      $display("FAIL rearm_one_pulse: rd_pulses=%0d done=%0b expected 1 1", rdp, check_done);
    end
    rearm();
  endtask

  task automatic test_descending();
    logic [DW-1:0] got;
    int beats, rdp, bad, t_rd, t_valid, t_done;
    bit to;
    run_capture(pack(v_desc), 1'b0, got, beats, rdp, bad, t_rd, t_valid, t_done, to);
    check_common("descending", pack(v_desc), got, beats, rdp, bad, to, 9, 1'b0);
    rearm();
  endtask

  initial begin
    sif.out_ready = 1'b0;
    test_reset();
    test_sorted();
    test_one_error();
    test_stall();
    test_mid_reset();
    test_stuck_done();
    test_descending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
